// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with sequential/redirect selection,
// IF/ID pipeline register, sticky misaligned-target flag and two saturating counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   redirect_i,
  input  logic [DATA_WIDTH-1:0]  target_i,
  output logic [DATA_WIDTH-1:0]  imem_addr_o,
  input  logic [DATA_WIDTH-1:0]  imem_rd_i,
  output logic [DATA_WIDTH-1:0]  instr_o,
  output logic [DATA_WIDTH-1:0]  PC_o,
  output logic [DATA_WIDTH-1:0]  PCPlus4_o,
  output logic                   valid_o,
  output logic                   misaligned_o,
  output logic [COUNT_WIDTH-1:0] fetch_count_o,
  output logic [COUNT_WIDTH-1:0] flush_count_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0]  pc_reg, pc_next, pc_plus4;
  logic [DATA_WIDTH-1:0]  instr_reg, pc_o_reg, pc4_reg;
  logic                   valid_reg, misaligned_reg;
  logic [COUNT_WIDTH-1:0] fetch_cnt_reg, flush_cnt_reg;
  logic                   ifid_load, squash;

  // Redirect comes from execute, which is never stalled, so it beats stall.
  always_comb begin
    pc_plus4 = pc_reg + DATA_WIDTH'(4);
    pc_next  = pc_plus4;
    if (redirect_i) begin
      pc_next = {target_i[DATA_WIDTH-1:2], 2'b00};
    end else if (stall_i) begin
      pc_next = pc_reg;
    end
    ifid_load = !flush_i && !stall_i;
    squash    = flush_i && valid_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      instr_reg      <= NOP;
      pc_o_reg       <= '0;
      pc4_reg        <= '0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      fetch_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      pc_reg <= pc_next;
      if (redirect_i && (target_i[1:0] != 2'b00)) begin
        misaligned_reg <= 1'b1;
      end
      if (flush_i) begin
        instr_reg <= NOP;
        pc_o_reg  <= '0;
        pc4_reg   <= '0;
        valid_reg <= 1'b0;
      end else if (!stall_i) begin
        instr_reg <= imem_rd_i;
        pc_o_reg  <= pc_reg;
        pc4_reg   <= pc_plus4;
        valid_reg <= 1'b1;
      end
      // Counters saturate at all-ones instead of wrapping.
      if (ifid_load && (fetch_cnt_reg != '1)) begin
        fetch_cnt_reg <= fetch_cnt_reg + COUNT_WIDTH'(1);
      end
      if (squash && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + COUNT_WIDTH'(1);
      end
    end
  end

  assign imem_addr_o   = pc_reg;
  assign instr_o       = instr_reg;
  assign PC_o          = pc_o_reg;
  assign PCPlus4_o     = pc4_reg;
  assign valid_o       = valid_reg;
  assign misaligned_o  = misaligned_reg;
  assign fetch_count_o = fetch_cnt_reg;
  assign flush_count_o = flush_cnt_reg;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register.
- Holds the program counter and drives the instruction-memory address.
- Selects the next PC from sequential increment or a redirect from execute.
- Registers the fetched instruction, PC and PC+4 into the decode stage, with stall, flush, valid tracking and a misaligned-target flag.
- Includes two performance counters.
- Sits directly upstream of the decode stage; its outputs feed the decode pipeline register path.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and target.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
COUNT_WIDTH, 16, width of each performance counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
stall_i  input  1  hazard stall; freezes the PC and the IF/ID register.
flush_i  input  1  squash the IF/ID contents (taken branch or jump).
redirect_i  input  1  load the PC from target_i.
target_i  input  DATA_WIDTH  redirect target address.
imem_addr_o  output  DATA_WIDTH  instruction-memory address; equals the PC register, combinational.
imem_rd_i  input  DATA_WIDTH  instruction-memory read data; combinational with imem_addr_o.
instr_o  output  DATA_WIDTH  IF/ID instruction.
PC_o  output  DATA_WIDTH  IF/ID PC.
PCPlus4_o  output  DATA_WIDTH  IF/ID PC+4.
valid_o  output  1  IF/ID holds a real instruction.
misaligned_o  output  1  sticky flag: a redirect target had target_i[1:0] != 0.
fetch_count_o  output  COUNT_WIDTH  number of instructions accepted into IF/ID.
flush_count_o  output  COUNT_WIDTH  number of valid IF/ID entries squashed.

Behaviour:
Reset (rst_n low at a rising edge):
- PC = RESET_PC.
- instr_o = 32'h0000_0013 (NOP).
- PC_o = 0, PCPlus4_o = 0, valid_o = 0.
- misaligned_o = 0, both counters = 0.
- Reset overrides every other input.
- Reset asserted mid-stall or mid-redirect discards all pending state; the first fetch after reset release is at RESET_PC.

PC register, next-state priority:
1. redirect_i = 1: PC <= target_i. Redirect beats stall_i, because the redirect comes from execute, which is not stalled.
2. else stall_i = 1: PC holds.
3. else: PC <= PC + 4, wrapping modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000).
- Target bits [1:0] are forced to 0 when loaded into the PC.
- If redirect_i = 1 and target_i[1:0] != 0, misaligned_o <= 1 and stays 1 until reset.

IF/ID register, priority:
1. flush_i = 1: instr_o <= NOP, PC_o <= 0, PCPlus4_o <= 0, valid_o <= 0. Flush beats stall.
2. else stall_i = 1: all IF/ID outputs hold.
3. else: instr_o <= imem_rd_i, PC_o <= PC, PCPlus4_o <= PC + 4, valid_o <= 1.

Latency:
- An instruction at address A appears on instr_o/PC_o one cycle after the PC equals A and the IF/ID register loads.
- After a redirect at edge N, the target instruction appears on instr_o at edge N+1, provided neither stall_i nor flush_i is high at that edge.

Counters:
- fetch_count_o increments on each edge where the IF/ID register loads (rule 3).
- flush_count_o increments on each edge where flush_i = 1 and valid_o = 1.
- Both counters saturate at all-ones; they do not wrap.

Simultaneous inputs:
- stall_i, flush_i and redirect_i all high: PC <= target_i, IF/ID flushed, flush_count increments if valid_o was 1.
- stall_i high with no redirect: imem_addr_o is stable for the whole stall.

Test Plan:
1. Reset release, no stall, imem returns address-based data -> instr_o/PC_o show 0x0, 0x4, 0x8 on consecutive cycles; valid_o rises one cycle after reset release; fetch_count_o = 3 after three cycles.
2. stall_i high for 3 cycles with PC = 0x10 -> imem_addr_o held at 0x10, instr_o/PC_o/valid_o frozen, fetch_count_o unchanged; fetch resumes at 0x14 after release.
3. redirect_i = 1, target_i = 0x200, flush_i = 1 in the same cycle -> valid_o = 0 and instr_o = 0x00000013 next cycle, then PC_o = 0x200, valid_o = 1; flush_count_o = 1.
4. stall_i = 1 with redirect_i = 1, target_i = 0x80 -> PC = 0x80 next cycle despite the stall; IF/ID holds its old contents.
5. target_i = 0x102 with redirect_i = 1 -> PC = 0x100; misaligned_o = 1 and stays high until rst_n low.
6. PC = 0xFFFFFFFC, no stall -> next PC = 0x0, PCPlus4_o = 0x0; with the counter forced to all-ones, a further fetch leaves fetch_count_o at 0xFFFF; rst_n low mid-stall clears all outputs next cycle.
